// File: rtl/pipe_pkg.sv
// Shared types and default widths for the ID->EX pipeline stage.
// The stage build is selected with macro PIPE_STAGE_SKID_EN (see pipe_stage.sv).
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module pipe_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage.sv
// ID->EX valid/ready pipeline register with flush and backpressure counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build (registered in_ready).
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                CNT_W    = DEF_CNT_W,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic              accept;
   logic              drain;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;

   // Flush kills both entries but leaves the data registers untouched.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = in_data;
                  state_d = ONE;
               end else begin
                  state_d = EMPTY;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_d  = in_data;
                  state_d = ONE;
               end else if (accept) begin
                  skid_d  = in_data;
                  state_d = FULL;
               end else if (drain) begin
                  state_d = EMPTY;
               end else begin
                  state_d = ONE;
               end
            end
            FULL: begin
               if (drain) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end else begin
                  state_d = FULL;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= RST_DATA;
         skid_q     <= RST_DATA;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;
`else
   // Single register: a held entry can be replaced in the cycle it drains.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY, ONE: begin
               if (accept) begin
                  main_d  = in_data;
                  state_d = ONE;
               end else if (drain) begin
                  state_d = EMPTY;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= RST_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   assign in_ready = !out_valid || out_ready;
`endif

   pipe_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage against a queue-based reference model.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  stall_cnt;

   int          passed;
   int          total;
   logic [31:0] q[$];
   logic [3:0]  m_cnt;
   bit          fresh;

   pipe_stage #(
      .DATA_W   (32),
      .CNT_W    (4),
      .RST_DATA (RST_VAL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock cycle: drive, check against the model, clock, update the model.
   task automatic cyc(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
      bit m_valid;
      bit m_ready;
      bit acc;
      bit drn;
      rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      m_valid = (q.size() > 0);
      m_ready = SKID ? (q.size() < 2) : ((q.size() == 0) || ordy);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, m_cnt});
      if (m_valid) chk("out_data", out_data, q[0]);
      else if (fresh) chk("out_data_rst", out_data, RST_VAL);
      acc = iv && m_ready;
      drn = m_valid && ordy;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_cnt = 4'd0;
         fresh = 1'b1;
      end else begin
         if (m_valid && !ordy && (m_cnt != 4'd15)) m_cnt = m_cnt + 4'd1;
         if (f) begin
            q.delete();
         end else begin
            if (drn) q.delete(0);
            if (acc) begin
               q.push_back(d);
               fresh = 1'b0;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      passed = 0; total = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      q.delete(); m_cnt = 4'd0; fresh = 1'b1;
      rst = 1'b0;

      // reset state, then streaming 1..8 with no bubbles
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, i, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("stream_stall0", {28'd0, stall_cnt}, 32'd0);

      // backpressure: A and B offered while stalled, then released
      cyc(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("bp_hold_a", out_data, 32'hA);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // flush while full, with 0xC offered in the flush cycle
      cyc(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 32'hC, 1'b0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // saturation: 20 stalled cycles on a held entry
      cyc(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("stall_sat", {28'd0, stall_cnt}, 32'd15);

      // reset in state ONE holding 0xD
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 32'hD, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 32'hE, 1'b0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", out_data, RST_VAL);
      chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);

      // held entry with out_ready low, then out_ready rising mid-cycle
      cyc(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h78, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h79, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
